pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Front-end stage directly upstream of the instruction-fetch/IF-ID block.
- Holds the program counter and selects the next PC from: sequential, jump, predicted branch, or misprediction recovery.
- Contains a direct-mapped branch history table (BHT) of 2-bit saturating counters. It supplies the prediction bits that the fetch stage consumes as ex_mem_branch_pridictor_bit_out.
- Updates the BHT from branch resolution in EX/MEM and raises pridictor_wrong on a mispredict.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_INDEX_BITS, 5, log2 of BHT entry count (32 entries), indexed by pc[BHT_INDEX_BITS+1:2].
- BHT_INIT, 2'b01, counter value written to every entry on reset (weakly not-taken).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- pc_write  input  1  from hazard detector; 0 = hold PC (stall)
- pc_select_jump  input  1  fetch stage decoded a J instruction
- pc_jump  input  32  jump target from fetch stage
- if_id_pc_src  input  1  fetch stage requests redirect to pc_branch_address
- pc_branch_address  input  32  predicted-taken target, or recovery address when pridictor_wrong=1
- ex_mem_branch_valid  input  1  one-cycle pulse: a branch resolved in EX/MEM
- ex_mem_branch_taken  input  1  actual outcome of the resolved branch
- ex_mem_branch_pc  input  32  address of the resolved branch
- ex_mem_branch_pred  input  2  counter value that branch was predicted with
- pc  output  32  current fetch address
- branch_pridictor_bit_out  output  2  BHT counter for the entry indexed by the current pc
- pridictor_wrong  output  1  mispredict flag, combinational

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc <= RESET_PC.
  - All BHT entries <= BHT_INIT.
  - Optional counters <= 0.
  - Reset asserted mid-operation discards any pending update.
- pridictor_wrong = ex_mem_branch_valid & (ex_mem_branch_taken != ex_mem_branch_pred[1]). It is 0 while rst_n=0.
- Next-PC priority, highest first:
  1. pridictor_wrong -> pc_branch_address. This applies even if pc_write=0; recovery overrides a stall.
  2. pc_write=0 -> hold pc.
  3. pc_select_jump -> pc_jump.
  4. if_id_pc_src -> pc_branch_address.
  5. Otherwise pc + 4. The add is 32-bit and wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Latency: the selected next PC appears on pc one cycle after selection.
- branch_pridictor_bit_out is a combinational read of BHT[pc index]. It is valid in the same cycle as pc.
- BHT update:
  - When ex_mem_branch_valid=1, entry BHT[ex_mem_branch_pc index] is updated at posedge.
  - Taken: increment, saturating at 2'b11.
  - Not taken: decrement, saturating at 2'b00.
  - The update starts from the stored entry value, not from ex_mem_branch_pred.
  - The update is independent of pc_write. The driver guarantees exactly one valid pulse per resolved branch.
- Read/write to the same index in the same cycle: the read returns the pre-update value; the new value is visible the next cycle. No bypass.
- Aliasing: branches sharing index bits share a counter, by design.
- pc[1:0] is never modified internally. Misaligned targets propagate unchanged.

Optional Feature:
- Macro BRANCH_PERF_COUNTERS_EN.
- Defined:
  - Adds output branch_count (32 bits), incremented on each ex_mem_branch_valid.
  - Adds output mispredict_count (32 bits), incremented on each pridictor_wrong.
  - Both wrap at 2^32 and reset to 0 synchronously.
- Undefined: neither port nor its registers exist, and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 clks, then release. Expect pc=RESET_PC and branch_pridictor_bit_out=2'b01 for every index. Free-run 3 clks and expect pc=0x0, 0x4, 0x8, 0xC.
- Stall versus recovery:
  - pc_write=0 for 3 clks -> pc holds at 0x10.
  - During the stall, assert ex_mem_branch_valid=1, taken=1, pred=2'b01 -> pridictor_wrong=1 and pc <= pc_branch_address (0x40) on the next edge.
- Priority: pc_select_jump=1 (pc_jump=0x100) together with if_id_pc_src=1 (pc_branch_address=0x200) -> pc=0x100.
- Counter saturation:
  - Four taken updates at ex_mem_branch_pc=0x24 -> entry 9 reads 10, 11, 11, 11.
  - Then five not-taken updates -> 10, 01, 00, 00, 00.
- Same-cycle read/write: pc=0x24 while an update to 0x24 (taken) arrives. Expect branch_pridictor_bit_out to show the old value that cycle and the new value the next cycle if pc is held.
- Perf counters (macro defined): 6 valid pulses, 2 of them mispredicted -> branch_count=6 and mispredict_count=2. Reset mid-run -> both counters 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   Front-end stage that sits directly upstream of the instruction-fetch/IF-ID
//   block. It owns the program counter and picks the next fetch address from
//   one of four sources: sequential (pc + 4), jump, predicted-taken branch, or
//   misprediction recovery. It also owns a direct-mapped branch history table
//   (BHT) of 2-bit saturating counters. The BHT supplies the prediction bits
//   that the fetch stage carries down the pipe, and it is trained by branch
//   resolutions reported from EX/MEM.
//
// Parameters:
//   RESET_PC        PC value loaded on reset.
//   BHT_INDEX_BITS  log2 of the BHT entry count. The table is indexed by
//                   pc[BHT_INDEX_BITS+1:2].
//   BHT_INIT        Counter value written to every entry on reset.
//
// Ports:
//   clk                  in   system clock; all state changes on the rising edge
//   rst_n                in   synchronous, active-low reset
//   pc_write             in   0 = hold the PC (hazard stall)
//   pc_select_jump       in   fetch stage decoded a J instruction
//   pc_jump[31:0]        in   jump target
//   if_id_pc_src         in   fetch stage requests a redirect to pc_branch_address
//   pc_branch_address    in   predicted-taken target, or the recovery address
//                             when pridictor_wrong=1
//   ex_mem_branch_valid  in   one-cycle pulse: a branch resolved in EX/MEM
//   ex_mem_branch_taken  in   actual outcome of that branch
//   ex_mem_branch_pc     in   address of that branch
//   ex_mem_branch_pred   in   counter value the branch was predicted with
//   pc[31:0]             out  current fetch address (registered)
//   branch_pridictor_bit_out[1:0]
//                        out  BHT counter for the entry indexed by pc
//                             (combinational read, same cycle as pc)
//   pridictor_wrong      out  mispredict flag (combinational)
//
// Optional feature (macro BRANCH_PERF_COUNTERS_EN):
//   branch_count[31:0]      out  number of resolved branches seen
//   mispredict_count[31:0]  out  number of mispredictions seen
//   Both counters wrap at 2^32 and clear on reset. When the macro is not
//   defined, the ports and their registers do not exist.
//
// Branch-resolution interface:
//   ex_mem_branch_valid is a qualifier pulse with no back-pressure. There is no
//   ready signal. Each cycle in which valid=1 carries exactly one resolved
//   branch, and the unit always accepts it on that rising edge. The taken, pc
//   and pred fields are only meaningful while valid=1. The upstream driver
//   guarantees one pulse per resolved branch.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          BHT_INDEX_BITS = 5,
  parameter logic [1:0]  BHT_INIT       = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        pc_select_jump,
  input  logic [31:0] pc_jump,
  input  logic        if_id_pc_src,
  input  logic [31:0] pc_branch_address,
  input  logic        ex_mem_branch_valid,
  input  logic        ex_mem_branch_taken,
  input  logic [31:0] ex_mem_branch_pc,
  input  logic [1:0]  ex_mem_branch_pred,
  output logic [31:0] pc,
  output logic [1:0]  branch_pridictor_bit_out,
  output logic        pridictor_wrong
`ifdef BRANCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
`endif
);

  localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [1:0]  bht_q [BHT_ENTRIES];
  logic [1:0]  bht_entry_d;

  logic [BHT_INDEX_BITS-1:0] fetch_idx;
  logic [BHT_INDEX_BITS-1:0] upd_idx;
  logic [1:0]                upd_old;
  logic [31:0]               pc_plus4;
  logic                      mispredict;

  // The table is indexed by word address. The low two PC bits are ignored for
  // indexing, and the bits above the index are ignored as well, so branches
  // that share index bits alias onto one counter by design.
  assign fetch_idx = pc_q[BHT_INDEX_BITS+1:2];
  assign upd_idx   = ex_mem_branch_pc[BHT_INDEX_BITS+1:2];

  // The bits below are deliberately not used (tag-less table, and only the
  // direction bit of the prediction matters). Folding them here keeps that
  // decision explicit.
  logic unused_in_bits;
  assign unused_in_bits = ^{ex_mem_branch_pc[31:BHT_INDEX_BITS+2],
                            ex_mem_branch_pc[1:0],
                            ex_mem_branch_pred[0]};

  // ---------------------------------------------------------------------------
  // Misprediction detection
  // ---------------------------------------------------------------------------
  // The prediction direction is the MSB of the counter the branch was fetched
  // with. The flag is forced low during reset so that a stale resolution
  // pulse cannot redirect the PC or count as a mispredict.
  assign mispredict      = ex_mem_branch_valid &
                           (ex_mem_branch_taken != ex_mem_branch_pred[1]);
  assign pridictor_wrong = rst_n & mispredict;

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  // Recovery sits above the stall. A mispredicted branch must flush the wrong
  // path even while the hazard unit is holding the front end, otherwise the
  // wrong path would keep being fetched after the stall lifts.
  // The 32-bit add wraps naturally. pc[1:0] is never forced, so a misaligned
  // target propagates unchanged and it is the fetch stage's job to trap it.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (pridictor_wrong) begin
      pc_d = pc_branch_address;
    end else if (!pc_write) begin
      pc_d = pc_q;
    end else if (pc_select_jump) begin
      pc_d = pc_jump;
    end else if (if_id_pc_src) begin
      pc_d = pc_branch_address;
    end
  end

  // ---------------------------------------------------------------------------
  // BHT counter update
  // ---------------------------------------------------------------------------
  // The new value is derived from the stored entry, not from the prediction
  // carried with the branch. Another branch aliasing on the same index may
  // have moved the counter since this branch was fetched.
  assign upd_old = bht_q[upd_idx];

  always_comb begin
    bht_entry_d = upd_old;
    if (ex_mem_branch_taken) begin
      if (upd_old != 2'b11) begin
        bht_entry_d = upd_old + 2'b01;
      end
    end else begin
      if (upd_old != 2'b00) begin
        bht_entry_d = upd_old - 2'b01;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // The BHT write does not depend on pc_write. Training must not be lost just
  // because the front end happens to be stalled when the branch resolves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= BHT_INIT;
      end
    end else begin
      pc_q <= pc_d;
      if (ex_mem_branch_valid) begin
        bht_q[upd_idx] <= bht_entry_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The read is not bypassed. When a write hits the entry being read in the
  // same cycle, the read returns the pre-update value, and the new value
  // appears on the next cycle.
  assign pc                       = pc_q;
  assign branch_pridictor_bit_out = bht_q[fetch_idx];

`ifdef BRANCH_PERF_COUNTERS_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] branch_count_q;
  logic [31:0] branch_count_d;
  logic [31:0] mispredict_count_q;
  logic [31:0] mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ex_mem_branch_valid) begin
      branch_count_d = branch_count_q + 32'd1;
    end
    if (pridictor_wrong) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed steps followed by a randomized phase, all in one initial block.
// A behavioural model (an integer PC plus an integer array of counters) is
// advanced once per clock from the next-PC priority rules and the
// saturating-counter rules. The model then predicts pc,
// branch_pridictor_bit_out and pridictor_wrong for the following cycle.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ENTRIES  = 32;

  // ---------------------------------------------------------------------------
  // Clock / DUT signals
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        pc_select_jump;
  logic [31:0] pc_jump;
  logic        if_id_pc_src;
  logic [31:0] pc_branch_address;
  logic        ex_mem_branch_valid;
  logic        ex_mem_branch_taken;
  logic [31:0] ex_mem_branch_pc;
  logic [1:0]  ex_mem_branch_pred;
  logic [31:0] pc;
  logic [1:0]  branch_pridictor_bit_out;
  logic        pridictor_wrong;
`ifdef BRANCH_PERF_COUNTERS_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_PC      (RESET_PC),
    .BHT_INDEX_BITS(5),
    .BHT_INIT      (2'b01)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .pc_write                (pc_write),
    .pc_select_jump          (pc_select_jump),
    .pc_jump                 (pc_jump),
    .if_id_pc_src            (if_id_pc_src),
    .pc_branch_address       (pc_branch_address),
    .ex_mem_branch_valid     (ex_mem_branch_valid),
    .ex_mem_branch_taken     (ex_mem_branch_taken),
    .ex_mem_branch_pc        (ex_mem_branch_pc),
    .ex_mem_branch_pred      (ex_mem_branch_pred),
    .pc                      (pc),
    .branch_pridictor_bit_out(branch_pridictor_bit_out),
    .pridictor_wrong         (pridictor_wrong)
`ifdef BRANCH_PERF_COUNTERS_EN
    ,
    .branch_count            (branch_count),
    .mispredict_count        (mispredict_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  int unsigned pc_m;
  int          bht_m [ENTRIES];
  int unsigned bc_m;
  int unsigned mc_m;

  int exp_up [4] = '{2, 3, 3, 3};
  int exp_dn [5] = '{2, 1, 0, 0, 0};

  function automatic int idx_of(input int unsigned addr);
    return int'((addr / 4) % ENTRIES);
  endfunction

  task automatic model_reset();
    pc_m = RESET_PC;
    for (int i = 0; i < ENTRIES; i++) bht_m[i] = 1;
    bc_m = 0;
    mc_m = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle against the model, advances the model using the
  // inputs presented this cycle, then moves one clock forward.
  task automatic tick();
    bit          exp_wrong;
    int unsigned nxt;
    int          k;
    #1;
    exp_wrong = rst_n && ex_mem_branch_valid &&
                (ex_mem_branch_taken != ex_mem_branch_pred[1]);
    chk("pc", pc, pc_m);
    chk("bht_read", {30'd0, branch_pridictor_bit_out}, 32'(bht_m[idx_of(pc_m)]));
    chk("pridictor_wrong", {31'd0, pridictor_wrong}, 32'(exp_wrong));
`ifdef BRANCH_PERF_COUNTERS_EN
    chk("branch_count", branch_count, bc_m);
    chk("mispredict_count", mispredict_count, mc_m);
`endif
    if (!rst_n) begin
      model_reset();
    end else begin
      if (exp_wrong)           nxt = pc_branch_address;
      else if (!pc_write)      nxt = pc_m;
      else if (pc_select_jump) nxt = pc_jump;
      else if (if_id_pc_src)   nxt = pc_branch_address;
      else                     nxt = pc_m + 4;
      if (ex_mem_branch_valid) begin
        k = idx_of(ex_mem_branch_pc);
        if (ex_mem_branch_taken) bht_m[k] = (bht_m[k] < 3) ? bht_m[k] + 1 : 3;
        else                     bht_m[k] = (bht_m[k] > 0) ? bht_m[k] - 1 : 0;
        bc_m++;
        if (exp_wrong) mc_m++;
      end
      pc_m = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic idle();
    pc_write            = 1'b1;
    pc_select_jump      = 1'b0;
    pc_jump             = 32'h0;
    if_id_pc_src        = 1'b0;
    pc_branch_address   = 32'h0;
    ex_mem_branch_valid = 1'b0;
    ex_mem_branch_taken = 1'b0;
    ex_mem_branch_pc    = 32'h0;
    ex_mem_branch_pred  = 2'b00;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] prev;
    bit         tk;

    // Reset, with a mismatching resolution pulse that must be ignored.
    rst_n = 1'b0;
    idle();
    ex_mem_branch_valid = 1'b1;
    ex_mem_branch_taken = 1'b1;
    ex_mem_branch_pred  = 2'b00;
    @(posedge clk);
    #1;
    model_reset();
    tick();
    tick();
    chk("reset_pc", pc, RESET_PC);

    // Sweep every index once: all counters read BHT_INIT.
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < ENTRIES; i++) begin
      chk("init_pc", pc, 32'(i * 4));
      chk("init_bht", {30'd0, branch_pridictor_bit_out}, 32'h1);
      tick();
    end

    // Re-reset and free-run.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("run_pc", pc, 32'(i * 4));
      tick();
    end

    // Stall holds the PC.
    pc_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_pc", pc, 32'h10);
      tick();
    end
    chk("stall_pc_end", pc, 32'h10);

    // Recovery overrides the stall.
    ex_mem_branch_valid = 1'b1;
    ex_mem_branch_taken = 1'b1;
    ex_mem_branch_pred  = 2'b01;
    ex_mem_branch_pc    = 32'h80;
    pc_branch_address   = 32'h40;
    #1;
    chk("recover_wrong", {31'd0, pridictor_wrong}, 32'h1);
    tick();
    chk("recover_pc", pc, 32'h40);

    // Jump beats branch redirect.
    idle();
    pc_select_jump    = 1'b1;
    pc_jump           = 32'h100;
    if_id_pc_src      = 1'b1;
    pc_branch_address = 32'h200;
    tick();
    chk("prio_jump", pc, 32'h100);

    idle();
    if_id_pc_src      = 1'b1;
    pc_branch_address = 32'h200;
    tick();
    chk("prio_branch", pc, 32'h200);

    // Stall beats jump.
    idle();
    pc_write       = 1'b0;
    pc_select_jump = 1'b1;
    pc_jump        = 32'h300;
    tick();
    chk("prio_stall", pc, 32'h200);

    // Recovery beats jump (predicted taken, actually not taken).
    idle();
    ex_mem_branch_valid = 1'b1;
    ex_mem_branch_taken = 1'b0;
    ex_mem_branch_pred  = 2'b10;
    ex_mem_branch_pc    = 32'h4;
    pc_branch_address   = 32'h500;
    pc_select_jump      = 1'b1;
    pc_jump             = 32'h600;
    tick();
    chk("prio_recover", pc, 32'h500);

    // 32-bit wrap and misaligned targets.
    idle();
    pc_select_jump = 1'b1;
    pc_jump        = 32'hFFFF_FFFC;
    tick();
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    idle();
    tick();
    chk("wrap_zero", pc, 32'h0);
    pc_select_jump = 1'b1;
    pc_jump        = 32'h103;
    tick();
    chk("misaligned", pc, 32'h103);
    idle();
    tick();
    chk("misaligned_inc", pc, 32'h107);

    // Park pc at 0x24 (entry 9) and train that entry.
    pc_select_jump = 1'b1;
    pc_jump        = 32'h24;
    tick();
    idle();
    pc_write = 1'b0;
    chk("sat_start", {30'd0, branch_pridictor_bit_out}, 32'h1);
    prev = 2'b01;
    for (int i = 0; i < 4; i++) begin
      ex_mem_branch_valid = 1'b1;
      ex_mem_branch_taken = 1'b1;
      ex_mem_branch_pred  = 2'b10;
      ex_mem_branch_pc    = 32'h24;
      #1;
      chk("same_cycle_old", {30'd0, branch_pridictor_bit_out}, {30'd0, prev});
      tick();
      chk("sat_up", {30'd0, branch_pridictor_bit_out}, 32'(exp_up[i]));
      prev = branch_pridictor_bit_out;
    end
    for (int i = 0; i < 5; i++) begin
      ex_mem_branch_valid = 1'b1;
      ex_mem_branch_taken = 1'b0;
      ex_mem_branch_pred  = 2'b00;
      ex_mem_branch_pc    = 32'h24;
      tick();
      chk("sat_down", {30'd0, branch_pridictor_bit_out}, 32'(exp_dn[i]));
    end
    chk("sat_pc_held", pc, 32'h24);

    // Six resolution pulses, two of them mispredicted, then reset mid-run.
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tk = (i % 2) == 1;
      ex_mem_branch_valid = 1'b1;
      ex_mem_branch_taken = tk;
      ex_mem_branch_pc    = 32'h40 + 32'(i * 4);
      ex_mem_branch_pred  = (i == 1 || i == 4) ? {~tk, 1'b0} : {tk, 1'b0};
      pc_branch_address   = 32'h800 + 32'(i * 16);
      tick();
    end
    idle();
    tick();
`ifdef BRANCH_PERF_COUNTERS_EN
    chk("perf_branches", branch_count, 32'd6);
    chk("perf_mispredicts", mispredict_count, 32'd2);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef BRANCH_PERF_COUNTERS_EN
    chk("perf_reset_branches", branch_count, 32'd0);
    chk("perf_reset_mispredicts", mispredict_count, 32'd0);
`endif

    // Randomized phase against the model.
    for (int n = 0; n < 400; n++) begin
      rst_n               = ($urandom_range(0, 49) != 0);
      pc_write            = ($urandom_range(0, 3) != 0);
      pc_select_jump      = ($urandom_range(0, 4) == 0);
      pc_jump             = $urandom;
      if_id_pc_src        = ($urandom_range(0, 3) == 0);
      pc_branch_address   = $urandom;
      ex_mem_branch_valid = ($urandom_range(0, 2) == 0);
      ex_mem_branch_taken = 1'($urandom_range(0, 1));
      ex_mem_branch_pc    = $urandom;
      ex_mem_branch_pred  = 2'($urandom_range(0, 3));
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
